mk8_debug_scan_bridge: RTL and testbench

MK8_DEBUG_SCAN_BRIDGE -- requirements
Module: mk8_debug_scan_bridge

---
 rtl/mk8_debug_scan_bridge.sv | 151 +++++++++++++++
 tb/tb_mk8_debug_scan_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mk8_debug_scan_bridge.sv
// Scan-chain bridge: IR/DR capture, shift and update into a CPU-side action handshake.
// Define DEBUG_SCAN_PARITY_EN to add an odd-parity bit on top of the data register.
module mk8_debug_scan_bridge #(
   parameter int unsigned IR_W     = 2,
   parameter int unsigned DR_W     = 38,
   parameter int unsigned IDLE_CYC = 4,
   localparam int unsigned N_CH    = 2**IR_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 shift_en,
   input  logic                 tdi,
   output logic                 tdo,
   input  logic                 vs_cdr,
   input  logic                 vs_sdr,
   input  logic                 vs_udr,
   input  logic                 vs_uir,
   input  logic                 jtag_state_rti,
   output logic                 st_ready_test_idle,
   input  logic [IR_W-1:0]      ir_in,
   output logic [IR_W-1:0]      ir_out,
   input  logic [N_CH*DR_W-1:0] cap_data,
   output logic                 act_valid,
   output logic [IR_W-1:0]      act_ir,
   output logic [DR_W-1:0]      act_data,
   input  logic                 act_ready,
   output logic                 overrun,
   output logic                 perr
);

`ifdef DEBUG_SCAN_PARITY_EN
   localparam int unsigned SR_W = DR_W + 1;
`else
   localparam int unsigned SR_W = DR_W;
`endif
   localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYC);

   logic [IR_W-1:0] ir_q, ir_d;
   logic [SR_W-1:0] sr_q, sr_d;
   logic            act_valid_q, act_valid_d;
   logic [IR_W-1:0] act_ir_q, act_ir_d;
   logic [DR_W-1:0] act_data_q, act_data_d;
   logic            overrun_q, overrun_d;
   logic [7:0]      idle_cnt_q, idle_cnt_d;
   logic [DR_W-1:0] cap_sel;
   logic [SR_W-1:0] sr_cap;
   logic            do_uir, do_cdr, do_sdr, do_udr, sr_ok;

   // Fixed strobe priority: uir > cdr > sdr > udr.
   assign do_uir = shift_en & vs_uir;
   assign do_cdr = shift_en & vs_cdr & ~vs_uir;
   assign do_sdr = shift_en & vs_sdr & ~vs_uir & ~vs_cdr;
   assign do_udr = shift_en & vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;

   always_comb begin
      cap_sel = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (ir_q == k[IR_W-1:0]) cap_sel = cap_data[k*DR_W +: DR_W];
      end
   end

`ifdef DEBUG_SCAN_PARITY_EN
   logic perr_q, perr_d;

   assign sr_cap = {~^cap_sel, cap_sel};
   assign sr_ok  = ^sr_q;
   assign perr   = perr_q;

   always_comb begin
      perr_d = perr_q;
      if (do_uir)                perr_d = 1'b0;
      else if (do_udr && !sr_ok) perr_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else       perr_q <= perr_d;
   end
`else
   assign sr_cap = cap_sel;
   assign sr_ok  = 1'b1;
   assign perr   = 1'b0;
`endif

   always_comb begin
      ir_d        = ir_q;
      sr_d        = sr_q;
      act_valid_d = act_valid_q;
      act_ir_d    = act_ir_q;
      act_data_d  = act_data_q;
      overrun_d   = overrun_q;
      // A consumed action retires unless a same-cycle update reloads it below.
      if (act_valid_q && act_ready) act_valid_d = 1'b0;
      if (do_uir) begin
         ir_d      = ir_in;
         overrun_d = 1'b0;
      end else if (do_cdr) begin
         sr_d = sr_cap;
      end else if (do_sdr) begin
         sr_d = {tdi, sr_q[SR_W-1:1]};
      end else if (do_udr && sr_ok) begin
         if (!act_valid_q || act_ready) begin
            act_data_d  = sr_q[DR_W-1:0];
            act_ir_d    = ir_q;
            act_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!jtag_state_rti)              idle_cnt_d = '0;
      else if (idle_cnt_q != IDLE_MAX)  idle_cnt_d = idle_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q        <= '0;
         sr_q        <= '0;
         act_valid_q <= 1'b0;
         act_ir_q    <= '0;
         act_data_q  <= '0;
         overrun_q   <= 1'b0;
         idle_cnt_q  <= '0;
      end else begin
         ir_q        <= ir_d;
         sr_q        <= sr_d;
         act_valid_q <= act_valid_d;
         act_ir_q    <= act_ir_d;
         act_data_q  <= act_data_d;
         overrun_q   <= overrun_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   always_comb begin
      ir_out    = '0;
      ir_out[0] = act_valid_q;
      ir_out[1] = overrun_q;
   end

   assign tdo                = sr_q[0];
   assign act_valid          = act_valid_q;
   assign act_ir             = act_ir_q;
   assign act_data           = act_data_q;
   assign overrun            = overrun_q;
   assign st_ready_test_idle = (idle_cnt_q == IDLE_MAX);

endmodule

// File: tb/tb_mk8_debug_scan_bridge.sv
// Randomized and directed bench for mk8_debug_scan_bridge against a behavioural model.
module tb_mk8_debug_scan_bridge;
   localparam int IR_W     = 2;
   localparam int DR_W     = 38;
   localparam int IDLE_CYC = 4;
   localparam int N_CH     = 4;
`ifdef DEBUG_SCAN_PARITY_EN
   localparam int SR_W = DR_W + 1;
`else
   localparam int SR_W = DR_W;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 shift_en = 1'b0;
   logic                 tdi = 1'b0;
   logic                 vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0, vs_uir = 1'b0;
   logic                 jtag_state_rti = 1'b0;
   logic [IR_W-1:0]      ir_in = '0;
   logic [N_CH*DR_W-1:0] cap_data = '0;
   logic                 act_ready = 1'b0;
   logic                 tdo, st_ready_test_idle, act_valid, overrun, perr;
   logic [IR_W-1:0]      ir_out, act_ir;
   logic [DR_W-1:0]      act_data;

   mk8_debug_scan_bridge #(.IR_W(IR_W), .DR_W(DR_W), .IDLE_CYC(IDLE_CYC)) dut (
      .clk(clk), .reset(reset), .shift_en(shift_en), .tdi(tdi), .tdo(tdo),
      .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
      .jtag_state_rti(jtag_state_rti), .st_ready_test_idle(st_ready_test_idle),
      .ir_in(ir_in), .ir_out(ir_out), .cap_data(cap_data),
      .act_valid(act_valid), .act_ir(act_ir), .act_data(act_data), .act_ready(act_ready),
      .overrun(overrun), .perr(perr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model state, advanced once per rising edge.
   int              m_ir, m_air, m_idle;
   logic [SR_W-1:0] m_sr;
   logic [DR_W-1:0] m_data;
   bit              m_valid, m_ovr, m_perr;

   always @(posedge clk) begin : model
      bit              was_valid, par_ok;
      logic [DR_W-1:0] w;
      was_valid = m_valid;
      if (reset) begin
         m_ir = 0; m_sr = '0; m_valid = 0; m_air = 0; m_data = '0;
         m_ovr = 0; m_perr = 0; m_idle = 0;
      end else begin
         if (was_valid && act_ready) m_valid = 0;
         if (jtag_state_rti) m_idle = (m_idle < IDLE_CYC) ? m_idle + 1 : m_idle;
         else                m_idle = 0;
         if (shift_en) begin
            if (vs_uir) begin
               m_ir = int'(ir_in); m_ovr = 0; m_perr = 0;
            end else if (vs_cdr) begin
               w    = DR_W'(cap_data >> (m_ir * DR_W));
               m_sr = SR_W'(w);
`ifdef DEBUG_SCAN_PARITY_EN
               if ($countones(w) % 2 == 0) m_sr = m_sr + (SR_W'(1) << DR_W);
`endif
            end else if (vs_sdr) begin
               m_sr = (m_sr >> 1) | (SR_W'(tdi) << (SR_W - 1));
            end else if (vs_udr) begin
`ifdef DEBUG_SCAN_PARITY_EN
               par_ok = ($countones(m_sr) % 2 == 1);
`else
               par_ok = 1'b1;
`endif
               if (!par_ok) m_perr = 1;
               else if (!was_valid || act_ready) begin
                  m_data = DR_W'(m_sr); m_air = m_ir; m_valid = 1;
               end else m_ovr = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("tdo", 64'(tdo), 64'(m_sr[0]));
         chk("ir_out", 64'(ir_out), 64'({m_ovr, m_valid}));
         chk("act_valid", 64'(act_valid), 64'(m_valid));
         chk("act_ir", 64'(act_ir), 64'(m_air));
         chk("act_data", 64'(act_data), 64'(m_data));
         chk("overrun", 64'(overrun), 64'(m_ovr));
         chk("perr", 64'(perr), 64'(m_perr));
         chk("st_ready", 64'(st_ready_test_idle), 64'(m_idle == IDLE_CYC));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [SR_W-1:0] with_par(input logic [DR_W-1:0] w);
`ifdef DEBUG_SCAN_PARITY_EN
      return {~^w, w};
`else
      return w;
`endif
   endfunction

   task automatic shift_raw(input logic [SR_W-1:0] v, output logic [SR_W-1:0] out);
      vs_sdr = 1'b1;
      for (int i = 0; i < SR_W; i++) begin
         out[i] = tdo;
         tdi    = v[i];
         tick();
      end
      vs_sdr = 1'b0;
   endtask

   task automatic pulse(input bit uir, input bit cdr, input bit udr);
      vs_uir = uir; vs_cdr = cdr; vs_udr = udr;
      tick();
      vs_uir = 1'b0; vs_cdr = 1'b0; vs_udr = 1'b0;
   endtask

   initial begin
      logic [SR_W-1:0] sout;
      logic [DR_W-1:0] dout;

      reset = 1'b1;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_tdo", 64'(tdo), 64'd0);
      chk("rst_ir_out", 64'(ir_out), 64'd0);
      chk("rst_act_valid", 64'(act_valid), 64'd0);
      chk("rst_act_data", 64'(act_data), 64'd0);

      // Capture channel 2 and shift it out while shifting a new word in.
      reset = 1'b0; shift_en = 1'b1;
      for (int k = 0; k < N_CH * DR_W; k++) cap_data[k] = 1'($urandom_range(0, 1));
      cap_data[2*DR_W +: DR_W] = 38'h2A_5555_AAAA;
      ir_in = 2'd2;
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      shift_raw(with_par(38'h15_0000_00FF), sout);
      dout = sout[DR_W-1:0];
      chk("cap_shift_out", 64'(dout), 64'(38'h2A_5555_AAAA));

      act_ready = 1'b1;
      pulse(0, 0, 1);
      chk("upd_valid", 64'(act_valid), 64'd1);
      chk("upd_data", 64'(act_data), 64'(38'h15_0000_00FF));
      chk("upd_ir", 64'(act_ir), 64'd2);
      tick();
      chk("hs_clear", 64'(act_valid), 64'd0);

      // Overrun: second update without a handshake is dropped.
      act_ready = 1'b0;
      pulse(0, 0, 1);
      chk("ovr_first_valid", 64'(act_valid), 64'd1);
      shift_raw(with_par(38'h0A_BCDE_1234), sout);
      pulse(0, 0, 1);
      chk("ovr_flag", 64'(overrun), 64'd1);
      chk("ovr_data_held", 64'(act_data), 64'(38'h15_0000_00FF));
      chk("ovr_ir_out", 64'(ir_out), 64'd3);
      ir_in = 2'd1;
      pulse(1, 0, 0);
      chk("uir_clr_ovr", 64'(overrun), 64'd0);
      act_ready = 1'b1;
      tick();
      chk("ovr_hs_clear", 64'(act_valid), 64'd0);
      act_ready = 1'b0;

      // Idle debounce: a 3-clock run never qualifies, the 4th clock of the next does.
      jtag_state_rti = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_run1", 64'(st_ready_test_idle), 64'd0);
      end
      jtag_state_rti = 1'b0;
      tick();
      chk("idle_gap", 64'(st_ready_test_idle), 64'd0);
      jtag_state_rti = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_run2", 64'(st_ready_test_idle), 64'(i == 3));
      end
      tick();
      chk("idle_sat", 64'(st_ready_test_idle), 64'd1);
      jtag_state_rti = 1'b0;
      tick();
      chk("idle_drop", 64'(st_ready_test_idle), 64'd0);

      // uir beats a simultaneous udr.
      ir_in = 2'd3;
      pulse(1, 0, 1);
      chk("uir_udr_valid", 64'(act_valid), 64'd0);
      pulse(0, 0, 1);
      chk("uir_udr_ir", 64'(act_ir), 64'd3);
      act_ready = 1'b1;
      tick();
      act_ready = 1'b0;

`ifdef DEBUG_SCAN_PARITY_EN
      shift_raw({1'b0, 38'h00_0000_0003}, sout);
      pulse(0, 0, 1);
      chk("par_bad_perr", 64'(perr), 64'd1);
      chk("par_bad_valid", 64'(act_valid), 64'd0);
      shift_raw(with_par(38'h31_2345_6789), sout);
      pulse(0, 0, 1);
      chk("par_ok_valid", 64'(act_valid), 64'd1);
      chk("par_ok_data", 64'(act_data), 64'(38'h31_2345_6789));
      pulse(1, 0, 0);
      chk("par_uir_clr", 64'(perr), 64'd0);
      act_ready = 1'b1;
      tick();
      act_ready = 1'b0;
`endif

      // Reset in the middle of a shift with a pending action.
      pulse(0, 0, 1);
      pulse(0, 1, 0);
      vs_sdr = 1'b1; tdi = 1'b1; jtag_state_rti = 1'b1;
      repeat (5) tick();
      reset = 1'b1; vs_udr = 1'b1; act_ready = 1'b1;
      tick();
      chk("rst_mid_tdo", 64'(tdo), 64'd0);
      chk("rst_mid_ir_out", 64'(ir_out), 64'd0);
      chk("rst_mid_valid", 64'(act_valid), 64'd0);
      chk("rst_mid_data", 64'(act_data), 64'd0);
      chk("rst_mid_air", 64'(act_ir), 64'd0);
      chk("rst_mid_st", 64'(st_ready_test_idle), 64'd0);
      reset = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0; act_ready = 1'b0; jtag_state_rti = 1'b0;

      // Randomized traffic checked every cycle by the model comparison.
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         shift_en  = ($urandom_range(0, 9) != 0);
         vs_uir    = ($urandom_range(0, 24) == 0);
         vs_cdr    = ($urandom_range(0, 14) == 0);
         vs_sdr    = ($urandom_range(0, 2) == 0);
         vs_udr    = ($urandom_range(0, 7) == 0);
         tdi       = 1'($urandom_range(0, 1));
         act_ready = ($urandom_range(0, 3) == 0);
         ir_in     = IR_W'($urandom);
         if ($urandom_range(0, 19) == 0) jtag_state_rti = ~jtag_state_rti;
         if ($urandom_range(0, 49) == 0)
            for (int k = 0; k < N_CH * DR_W; k++) cap_data[k] = 1'($urandom_range(0, 1));
         tick();
      end
      reset = 1'b0; vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
      tick(); tick();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
